// File: rtl/xge_tx_arbiter_if.sv
// Bundle of the two source streams and the MAC transmit handshake.
// The arbiter uses the slave view; the surrounding logic drives the master view.
interface xge_tx_arbiter_if;
  logic [63:0] s0_data;
  logic [7:0]  s0_keep;
  logic        s0_valid;
  logic        s0_last;
  logic        s0_ready;
  logic [63:0] s1_data;
  logic [7:0]  s1_keep;
  logic        s1_valid;
  logic        s1_last;
  logic        s1_ready;
  logic        tx_start;
  logic [63:0] tx_data;
  logic [7:0]  tx_data_valid;
  logic        tx_ack;

  modport slave (
    input  s0_data, s0_keep, s0_valid, s0_last,
    output s0_ready,
    input  s1_data, s1_keep, s1_valid, s1_last,
    output s1_ready,
    output tx_start, tx_data, tx_data_valid,
    input  tx_ack
  );

  modport master (
    output s0_data, s0_keep, s0_valid, s0_last,
    input  s0_ready,
    output s1_data, s1_keep, s1_valid, s1_last,
    input  s1_ready,
    input  tx_start, tx_data, tx_data_valid,
    output tx_ack
  );
endinterface

// File: rtl/xge_tx_arbiter.sv
// Two-source frame arbiter in front of the MAC transmit port: grants whole frames,
// runs the tx_start/tx_ack handshake, terminates frames and enforces the idle gap.
module xge_tx_arbiter #(
  parameter int unsigned IFG_CYCLES  = 2,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter bit          FIXED_PRIO  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  xge_tx_arbiter_if.slave bus,
  output logic            grant_id,
  output logic            busy,
  output logic            frame_done,
  output logic            underrun,
  output logic            ack_timeout
);
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StReq   = 3'd1;
  localparam logic [2:0] StXfer  = 3'd2;
  localparam logic [2:0] StTail  = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;
  localparam logic [2:0] StGap   = 3'd5;

  localparam logic [15:0] AckTimeout = 16'(ACK_TIMEOUT);
  localparam logic [3:0]  IfgCycles  = 4'(IFG_CYCLES);
  localparam logic [2:0]  StAfter    = (IFG_CYCLES == 0) ? StIdle : StGap;

  logic [2:0]  state_q, state_d;
  logic        grant_q, grant_d;
  logic        rr_last_q, rr_last_d;
  logic        tx_start_q, tx_start_d;
  logic [63:0] tx_data_q, tx_data_d;
  logic [7:0]  tx_valid_q, tx_valid_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  gap_q, gap_d;
  logic        frame_done_q, frame_done_d;
  logic        underrun_q, underrun_d;
  logic        ack_timeout_q, ack_timeout_d;

  logic        winner, src, take, end_frame;
  logic [63:0] sel_data;
  logic [7:0]  sel_keep;
  logic        sel_valid, sel_last;

  // Round-robin only matters when both request; otherwise the lone requester wins.
  assign winner = (bus.s0_valid && bus.s1_valid && !FIXED_PRIO) ? !rr_last_q : !bus.s0_valid;

  // Before a grant exists the mux previews the winner's head word.
  assign src       = (state_q == StIdle) ? winner : grant_q;
  assign sel_data  = src ? bus.s1_data  : bus.s0_data;
  assign sel_keep  = src ? bus.s1_keep  : bus.s0_keep;
  assign sel_valid = src ? bus.s1_valid : bus.s0_valid;
  assign sel_last  = src ? bus.s1_last  : bus.s0_last;

  always_comb begin
    case (state_q)
      StReq:   take = bus.tx_ack;
      StXfer:  take = sel_valid;
      StDrain: take = 1'b1;
      default: take = 1'b0;
    endcase
  end

  assign bus.s0_ready      = take & ~grant_q;
  assign bus.s1_ready      = take & grant_q;
  assign bus.tx_start      = tx_start_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_data_valid = tx_valid_q;
  assign grant_id          = grant_q;
  assign busy              = (state_q != StIdle);
  assign frame_done        = frame_done_q;
  assign underrun          = underrun_q;
  assign ack_timeout       = ack_timeout_q;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_last_d     = rr_last_q;
    tx_start_d    = tx_start_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    timer_d       = timer_q;
    gap_d         = gap_q;
    frame_done_d  = 1'b0;
    underrun_d    = 1'b0;
    ack_timeout_d = 1'b0;
    end_frame     = 1'b0;
    case (state_q)
      StIdle: begin
        tx_start_d = 1'b0;
        tx_data_d  = '0;
        tx_valid_d = '0;
        if (bus.s0_valid || bus.s1_valid) begin
          state_d    = StReq;
          grant_d    = winner;
          tx_start_d = 1'b1;
          tx_data_d  = sel_data;
          tx_valid_d = sel_last ? sel_keep : 8'hFF;
          timer_d    = 16'd1;
        end
      end
      StReq: begin
        if (bus.tx_ack) begin
          // The first word stays on tx_data for the cycle the MAC consumes it.
          tx_start_d = 1'b0;
          if (!sel_last) begin
            state_d = StXfer;
          end else if (sel_keep == 8'hFF) begin
            state_d = StTail;
          end else begin
            frame_done_d = 1'b1;
            end_frame    = 1'b1;
          end
        end else if (timer_q >= AckTimeout) begin
          tx_start_d    = 1'b0;
          tx_data_d     = '0;
          tx_valid_d    = '0;
          ack_timeout_d = 1'b1;
          state_d       = StDrain;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StXfer: begin
        if (!sel_valid) begin
          // A non-FF valid closes the frame at the MAC.
          tx_data_d  = '0;
          tx_valid_d = '0;
          underrun_d = 1'b1;
          state_d    = StDrain;
        end else begin
          tx_data_d = sel_data;
          if (!sel_last) begin
            tx_valid_d = 8'hFF;
          end else begin
            tx_valid_d = sel_keep;
            if (sel_keep == 8'hFF) begin
              state_d = StTail;
            end else begin
              frame_done_d = 1'b1;
              end_frame    = 1'b1;
            end
          end
        end
      end
      StTail: begin
        tx_data_d    = '0;
        tx_valid_d   = '0;
        frame_done_d = 1'b1;
        end_frame    = 1'b1;
      end
      StDrain: begin
        tx_data_d  = '0;
        tx_valid_d = '0;
        if (sel_valid && sel_last) end_frame = 1'b1;
      end
      StGap: begin
        tx_data_d  = '0;
        tx_valid_d = '0;
        if (gap_q >= IfgCycles) state_d = StIdle;
        else gap_d = gap_q + 4'd1;
      end
      default: state_d = StIdle;
    endcase
    if (end_frame) begin
      state_d   = StAfter;
      rr_last_d = grant_q;
      gap_d     = 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      grant_q       <= 1'b0;
      rr_last_q     <= 1'b1;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      tx_valid_q    <= '0;
      timer_q       <= '0;
      gap_q         <= '0;
      frame_done_q  <= 1'b0;
      underrun_q    <= 1'b0;
      ack_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_last_q     <= rr_last_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      timer_q       <= timer_d;
      gap_q         <= gap_d;
      frame_done_q  <= frame_done_d;
      underrun_q    <= underrun_d;
      ack_timeout_q <= ack_timeout_d;
    end
  end
endmodule
